// File: rtl/engine_pkg.sv
// Shared types and mode encodings for the engine power sequencer.
package engine_pkg;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      IGNITE = 2'd1,
      ON     = 2'd2
   } eng_state_t;

   localparam logic [1:0] MODE_NONE   = 2'b00;
   localparam logic [1:0] MODE_MANUAL = 2'b01;
   localparam logic [1:0] MODE_SEMI   = 2'b10;
   localparam logic [1:0] MODE_AUTO   = 2'b11;

endpackage

// File: rtl/tick_counter.sv
// Saturating tick counter with synchronous clear and terminal-count flag.
module tick_counter #(
   parameter int CNT_W = 10,
   parameter int LIMIT = 999
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != LIM)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tc = (r_cnt == LIM);

endmodule

// File: rtl/engine_sequencer.sv
// Engine power sequencer: hold-to-start ignition, kill arbitration, stall detect.
//   state  | meaning
//   OFF    | engine unpowered, light dark
//   IGNITE | start request being held; light blinks
//   ON     | engine powered, light steady
module engine_sequencer
   import engine_pkg::*;
#(
   parameter int HOLD_MS  = 1000,
   parameter int BLINK_MS = 250,
   parameter int CNT_W    = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_ms,
   input  logic [1:0] global_state,
   input  logic       power_on_btn,
   input  logic       power_off_btn,
   input  logic       auto_power_req,
   input  logic       clutch,
   input  logic       reverse_shift,
   output logic       power,
   output logic       power_light,
   output logic       stall
);

   eng_state_t r_state, w_next;
   logic [1:0] r_mode;
   logic       r_rev;
   logic       r_light;
   logic       r_stall;

   logic w_mode_chg, w_start, w_stall, w_kill;
   logic w_hold_tc, w_blink_tc;
   logic w_stay_ign, w_blink_wrap, w_light_next;

   assign w_mode_chg = (global_state != r_mode);
   // auto_power_req only counts in the semi-auto and auto modes (mode bit 1 set)
   assign w_start    = power_on_btn | (auto_power_req & r_mode[1]);
   assign w_stall    = (r_mode == MODE_MANUAL) && (r_state == ON) &&
                       (reverse_shift != r_rev) && !clutch;
   assign w_kill     = power_off_btn | (global_state == MODE_NONE) | w_stall;

   always_comb begin
      w_next = r_state;
      if (w_mode_chg || w_kill) begin
         w_next = OFF;
      end else begin
         case (r_state)
            OFF:     if (w_start && (r_mode != MODE_NONE)) w_next = IGNITE;
            IGNITE: begin
               if (!w_start)                   w_next = OFF;
               else if (tick_ms && w_hold_tc)  w_next = ON;
            end
            ON:      w_next = ON;
            default: w_next = OFF;
         endcase
      end
   end

   // Both counters run only while staying in IGNITE; any exit clears them.
   assign w_stay_ign   = (r_state == IGNITE) && (w_next == IGNITE);
   assign w_blink_wrap = w_stay_ign && tick_ms && w_blink_tc;

   tick_counter #(.CNT_W(CNT_W), .LIMIT(HOLD_MS - 1)) u_hold (
      .clk   (clk),
      .rst   (rst),
      .i_clr (!w_stay_ign),
      .i_en  (tick_ms && w_stay_ign),
      .o_tc  (w_hold_tc)
   );

   tick_counter #(.CNT_W(CNT_W), .LIMIT(BLINK_MS - 1)) u_blink (
      .clk   (clk),
      .rst   (rst),
      .i_clr (!w_stay_ign || w_blink_wrap),
      .i_en  (tick_ms && w_stay_ign),
      .o_tc  (w_blink_tc)
   );

   always_comb begin
      w_light_next = 1'b0;
      case (w_next)
         ON:      w_light_next = 1'b1;
         IGNITE:  w_light_next = (r_state != IGNITE) ? 1'b1 :
                                 (w_blink_wrap ? ~r_light : r_light);
         default: w_light_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= OFF;
         r_mode  <= MODE_NONE;
         r_rev   <= 1'b0;
         r_light <= 1'b0;
         r_stall <= 1'b0;
      end else begin
         r_state <= w_next;
         r_mode  <= global_state;
         r_rev   <= reverse_shift;
         r_light <= w_light_next;
         r_stall <= w_stall;
      end
   end

   assign power       = (r_state == ON);
   assign power_light = r_light;
   assign stall       = r_stall;

endmodule

// File: tb/tb_engine_sequencer.sv
// Directed bench for engine_sequencer at default parameters (1000-tick hold, 250-tick blink).
module tb_engine_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_ms = 1'b0;
   logic [1:0] global_state = 2'b00;
   logic       power_on_btn = 1'b0;
   logic       power_off_btn = 1'b0;
   logic       auto_power_req = 1'b0;
   logic       clutch = 1'b0;
   logic       reverse_shift = 1'b0;
   logic       power, power_light, stall;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   engine_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .tick_ms        (tick_ms),
      .global_state   (global_state),
      .power_on_btn   (power_on_btn),
      .power_off_btn  (power_off_btn),
      .auto_power_req (auto_power_req),
      .clutch         (clutch),
      .reverse_shift  (reverse_shift),
      .power          (power),
      .power_light    (power_light),
      .stall          (stall)
   );

   task automatic chk(input string tag, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         tick_ms = 1'b1;
         @(posedge clk); #1;
         tick_ms = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   // From OFF with start_req held and mode settled: enter IGNITE, then 1000 ticks.
   task automatic reach_on(input string tag);
      cyc(1);
      chk({tag, "_ign_light"}, power_light, 1'b1);
      tick_n(999);
      chk({tag, "_999"}, power, 1'b0);
      tick_n(1);
      chk({tag, "_1000"}, power, 1'b1);
   endtask

   initial begin
      #12;
      chk("rst_power", power, 1'b0);
      chk("rst_light", power_light, 1'b0);
      chk("rst_stall", stall, 1'b0);
      @(negedge clk); rst = 1'b1;
      cyc(1);
      global_state = 2'b01;
      cyc(1);

      // async reset mid-IGNITE at hold count 500 (light is in its second lit half)
      power_on_btn = 1'b1;
      cyc(1);
      tick_n(500);
      chk("pre_rst_light", power_light, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_power", power, 1'b0);
      chk("async_rst_light", power_light, 1'b0);
      @(negedge clk); rst = 1'b1;
      cyc(1);                      // mode_q reloads from 00 to 01
      reach_on("after_rst");

      power_on_btn  = 1'b0;
      power_off_btn = 1'b1;
      cyc(1);
      power_off_btn = 1'b0;
      chk("kill_off_btn", power, 1'b0);

      // normal start with blink pattern
      power_on_btn = 1'b1;
      cyc(1);
      chk("blink_entry", power_light, 1'b1);
      tick_n(249);
      chk("blink_t249", power_light, 1'b1);
      tick_n(1);
      chk("blink_t250", power_light, 1'b0);
      tick_n(250);
      chk("blink_t500", power_light, 1'b1);
      tick_n(499);
      chk("blink_t999", power_light, 1'b0);
      chk("norm_t999_power", power, 1'b0);
      tick_ms = 1'b1;
      cyc(1);
      tick_ms = 1'b0;
      chk("norm_t1000_power", power, 1'b1);
      chk("norm_t1000_light", power_light, 1'b1);
      cyc(1);

      // manual stall: reverse toggles with clutch released
      power_on_btn  = 1'b0;
      reverse_shift = 1'b1;
      cyc(1);
      chk("stall_pulse", stall, 1'b1);
      chk("stall_power", power, 1'b0);
      cyc(1);
      chk("stall_one_cycle", stall, 1'b0);

      // early release on tick 999: drop wins, counter restarts
      power_on_btn = 1'b1;
      cyc(1);
      tick_n(998);
      tick_ms = 1'b1;
      power_on_btn = 1'b0;
      cyc(1);
      tick_ms = 1'b0;
      chk("early_rel_power", power, 1'b0);
      chk("early_rel_light", power_light, 1'b0);
      cyc(1);
      power_on_btn = 1'b1;
      reach_on("repress");

      // reverse toggle with clutch pressed: no stall
      clutch = 1'b1;
      reverse_shift = 1'b0;
      cyc(1);
      chk("clutch_no_stall", stall, 1'b0);
      chk("clutch_power", power, 1'b1);
      cyc(1);
      chk("clutch_power2", power, 1'b1);
      clutch = 1'b0;

      // mode change 01->10 with auto request in the same cycle
      power_on_btn   = 1'b0;
      global_state   = 2'b10;
      auto_power_req = 1'b1;
      cyc(1);
      chk("modechg_power", power, 1'b0);
      chk("modechg_light", power_light, 1'b0);
      cyc(1);
      chk("semi_ignite", power_light, 1'b1);
      tick_n(1000);
      chk("semi_on", power, 1'b1);

      // mode none forces off and blocks ignition
      global_state = 2'b00;
      power_on_btn = 1'b1;
      cyc(1);
      chk("none_power", power, 1'b0);
      tick_n(5);
      chk("none_no_start", power_light, 1'b0);
      power_on_btn = 1'b0;

      // auto mode ignition from auto_power_req
      global_state = 2'b11;
      cyc(1);
      reach_on("auto");
      auto_power_req = 1'b0;
      power_off_btn  = 1'b1;
      cyc(1);
      power_off_btn  = 1'b0;
      chk("auto_kill", power, 1'b0);

      // auto request ignored in manual mode
      global_state   = 2'b01;
      auto_power_req = 1'b1;
      cyc(2);
      chk("manual_auto_light", power_light, 1'b0);
      tick_n(1000);
      chk("manual_auto_power", power, 1'b0);
      auto_power_req = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/engine_sequencer.md
# engine_sequencer

Engine power sequencer for the car controller. It arbitrates ignition and shutdown requests from the front-panel buttons and the semi-auto/auto driving controllers. It enforces the 1 s hold-to-start rule and forces the engine off on a mode change, an invalid mode or a manual-mode stall. It drives the engine power flag consumed by the drive datapath and the dashboard power light.

## Interface
Parameters:
- HOLD_MS, 1000, ticks of continuous request required to start
- BLINK_MS, 250, light half-period while igniting, in ticks
- CNT_W, 10, width of hold and blink counters (must hold HOLD_MS-1)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- tick_ms  in  1  one-clk-wide pulse at 1 kHz from the clock divider
- global_state  in  2  mode: 00 none, 01 manual, 10 semi-auto, 11 auto
- power_on_btn  in  1  debounced level, held to request ignition
- power_off_btn  in  1  debounced level, shutdown request
- auto_power_req  in  1  ignition request level from semi-auto/auto controller
- clutch  in  1  clutch pressed
- reverse_shift  in  1  reverse gear switch level
- power  out  1  engine powered (registered)
- power_light  out  1  dashboard light (registered)
- stall  out  1  one-cycle pulse on manual-mode stall

## Operation
- FSM states: OFF, IGNITE, ON. mode_q latches global_state; rev_q latches reverse_shift.
- start_req = power_on_btn, or auto_power_req when mode_q is 10 or 11.
- Per-cycle priority, highest first:
  1. Mode change: global_state != mode_q. Go to OFF, clear counters, update mode_q.
  2. Kill: power_off_btn, global_state==00, or a stall. Go to OFF and clear counters.
  3. Normal transitions:
     - OFF→IGNITE when start_req and mode_q!=00. The hold counter is cleared.
     - IGNITE: on each tick_ms with start_req, increment the hold counter. When the counter equals HOLD_MS-1 on a tick, go to ON and clear it. If start_req drops, go to OFF and clear the counter.
     - ON stays ON until a kill or a mode change. start_req in ON is ignored.
- Stall condition: mode_q==01, state ON, reverse_shift != rev_q, and clutch==0. It asserts stall for exactly one cycle and produces the kill.
- rev_q updates every cycle regardless of state.
- Outputs:
  - power = (state==ON).
  - power_light = 1 in ON and 0 in OFF.
  - In IGNITE, power_light starts at 1 on entry and toggles every BLINK_MS ticks; the blink counter wraps to 0 on each toggle.
- Counters never wrap past their limits. The hold counter saturates at HOLD_MS-1.

## Timing
- Reset (async assert, sync release): state OFF, mode_q=00, rev_q=0, counters 0, power=0, power_light=0, stall=0.
- All outputs are registered and change on the clk edge after the causing condition. There is no combinational input→output path.
- Ignition latency:
  - IGNITE is entered 1 clk after start_req is sampled in OFF.
  - power rises 1 clk after the HOLD_MS-th tick_ms inside IGNITE. This is ≈1000 ms at defaults.
- Kill latency: power falls 1 clk after power_off_btn, a stall or global_state==00 is sampled.
- A simultaneous mode change and start_req resolves to OFF. Ignition needs a new request in a later cycle, with start_req still high.
- A tick on the same cycle start_req drops: the drop wins and the counter clears.
- An async reset during IGNITE or ON gives immediate OFF and all outputs 0.

## Structure
- Package engine_pkg:
  - state enum {OFF, IGNITE, ON}
  - mode constants MODE_NONE, MODE_MANUAL, MODE_SEMI, MODE_AUTO
- Sub-module tick_counter: a CNT_W-bit counter with clear, enable-on-tick and terminal-count flag. It is instantiated twice, for the hold and blink counters.
- The FSM, stall detect and output registers live in engine_sequencer.

## Test plan
- **Reset:** rst=0 mid-IGNITE (hold count 500) → power=0, power_light=0 immediately. After release, 1000 ticks are needed to start.
- **Normal start:** global_state=01, power_on_btn held → power=1 exactly 1 clk after tick 1000. power_light blinks 1/0 with 250-tick halves before that.
- **Early release:** button released at tick 999 → OFF, power=0. Re-press then needs 1000 ticks again.
- **Auto source:**
  - global_state=11, auto_power_req held 1000 ticks → power=1.
  - The same stimulus with global_state=01 → power stays 0.
- **Kills:**
  - ON, then power_off_btn pulse → power=0 next clk.
  - ON, then global_state 01→10 → power=0, and mode_q=10.
  - ON, then global_state=00 → power=0.
- **Stall:**
  - Manual ON, reverse_shift toggles with clutch=0 → stall high 1 clk, power=0.
  - The same toggle with clutch=1 → power stays 1 and stall stays 0.
